// File: rtl/ifu_fetch.sv
`default_nettype none
// ============================================================================
//  Module   : ifu_fetch
//  Purpose  : Instruction fetch unit. Holds the PC, issues one-at-a-time
//             requests to instruction memory, buffers the returned word in
//             a single-entry buffer and presents it to decode. Freezes the
//             buffer while IFU_run is low; flushes on a taken-branch redirect.
//  Ports    : clk, reset             - clock, synchronous active-high reset
//             IFU_run                - run enable (0 = stall, holds buffer)
//             redirect_valid/_pc     - taken branch/jump from execute
//             imem_req_valid/_addr/_ready - request handshake to imem
//             imem_rsp_valid/_data   - in-order response from imem
//             if_valid/if_pc/if_instr - registered instruction buffer
//             stall_cnt/fetch_cnt    - performance counters
//  Config   : define IFU_PERF_EN to build the performance counters;
//             otherwise stall_cnt/fetch_cnt are tied to zero.
//  Revision : 1.0 - initial release
// ============================================================================
module ifu_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        IFU_run,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr,
  output logic [31:0] stall_cnt,
  output logic [31:0] fetch_cnt
);

  localparam logic [31:0] C_NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_REQ  = 2'd0,
    ST_WAIT = 2'd1,
    ST_FULL = 2'd2,
    ST_DROP = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        if_valid_q, if_valid_d;
  logic [31:0] if_pc_q, if_pc_d;
  logic [31:0] if_instr_q, if_instr_d;

  // Low two bits of the redirect target are dropped by masking so the
  // whole input bus is consumed.
  logic [31:0] w_redirect_addr;
  assign w_redirect_addr = redirect_pc & 32'hFFFF_FFFC;

  // A request goes out from REQ, or from FULL when the buffered
  // instruction is consumed this cycle. A redirect suppresses it so the
  // stale PC never reaches memory.
  assign imem_req_valid = !reset && !redirect_valid &&
                          ((state_q == ST_REQ) || ((state_q == ST_FULL) && IFU_run));
  assign imem_req_addr  = pc_q;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    if_valid_d = if_valid_q;
    if_pc_d    = if_pc_q;
    if_instr_d = if_instr_q;

    if (redirect_valid) begin
      pc_d       = w_redirect_addr;
      if_valid_d = 1'b0;
      // An outstanding request whose response has not arrived yet must
      // have that response swallowed later; otherwise restart cleanly.
      if (((state_q == ST_WAIT) || (state_q == ST_DROP)) && !imem_rsp_valid) begin
        state_d = ST_DROP;
      end else begin
        state_d = ST_REQ;
      end
    end else begin
      case (state_q)
        ST_REQ: begin
          if (imem_req_ready) begin
            state_d = ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (imem_rsp_valid) begin
            if_instr_d = imem_rsp_data;
            if_pc_d    = pc_q;
            if_valid_d = 1'b1;
            pc_d       = pc_q + 32'd4;
            state_d    = ST_FULL;
          end
        end
        ST_FULL: begin
          if (IFU_run) begin
            if_valid_d = 1'b0;
            state_d    = imem_req_ready ? ST_WAIT : ST_REQ;
          end
        end
        ST_DROP: begin
          if (imem_rsp_valid) begin
            state_d = ST_REQ;
          end
        end
        default: begin
          state_d = ST_REQ;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_REQ;
      pc_q       <= RESET_PC;
      if_valid_q <= 1'b0;
      if_pc_q    <= RESET_PC;
      if_instr_q <= C_NOP;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      if_valid_q <= if_valid_d;
      if_pc_q    <= if_pc_d;
      if_instr_q <= if_instr_d;
    end
  end

  assign if_valid = if_valid_q;
  assign if_pc    = if_pc_q;
  assign if_instr = if_instr_q;

`ifdef IFU_PERF_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] fetch_cnt_q, fetch_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    fetch_cnt_d = fetch_cnt_q;
    if ((state_q == ST_FULL) && !IFU_run) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
    // Only responses that actually land in the buffer are counted.
    if (!redirect_valid && (state_q == ST_WAIT) && imem_rsp_valid) begin
      fetch_cnt_d = fetch_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= 32'd0;
      fetch_cnt_q <= 32'd0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      fetch_cnt_q <= fetch_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign fetch_cnt = fetch_cnt_q;
`else
  assign stall_cnt = 32'd0;
  assign fetch_cnt = 32'd0;
`endif

endmodule
`default_nettype wire

// File: doc/ifu_fetch.md
# ifu_fetch

Instruction fetch unit for the in-order RISC-V core. Holds the PC, issues one-at-a-time requests to instruction memory, buffers the returned word and presents it to decode. Sits directly upstream of decode and downstream of the run control unit: it freezes while `IFU_run` is low and flushes on a taken-branch redirect from execute.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC loaded on reset.
- `clk` in 1: single clock, all state on rising edge.
- `reset` in 1: synchronous, active-high.
- `IFU_run` in 1: run enable from run control; 0 = data-conflict stall.
- `redirect_valid` in 1: taken branch/jump from execute.
- `redirect_pc` in 32: new PC; bits [1:0] ignored (treated as 00).
- `imem_req_valid` out 1: fetch request.
- `imem_req_addr` out 32: word-aligned fetch address.
- `imem_req_ready` in 1: memory accepts request this cycle.
- `imem_rsp_valid` in 1: response data valid; in order, at least 1 cycle after accept.
- `imem_rsp_data` in 32: fetched instruction.
- `if_valid` out 1: instruction buffer holds a valid instruction.
- `if_pc` out 32: PC of buffered instruction.
- `if_instr` out 32: buffered instruction.
- `stall_cnt` out 32: stall-cycle counter (see Configuration).
- `fetch_cnt` out 32: fetched-instruction counter (see Configuration).

## Operation
- At most one outstanding request. A single-entry buffer drives the `if_*` outputs.
- States: REQ, WAIT, FULL, DROP.
- REQ: `imem_req_valid`=1, `imem_req_addr`=pc. With `imem_req_ready`, go to WAIT.
- WAIT: on `imem_rsp_valid`, load buffer (`if_instr`=data, `if_pc`=pc), set `if_valid`, pc<=pc+4, go to FULL.
- FULL with `IFU_run`=0: hold everything. `imem_req_valid`=0.
- FULL with `IFU_run`=1: the buffered instruction is consumed at this edge and `if_valid` clears.
  - `imem_req_valid`=1 in the same cycle. If ready, go to WAIT; otherwise go to REQ.
- DROP: discard the next `imem_rsp_valid`, then go to REQ.
- `IFU_run` affects only FULL. A request in REQ/WAIT proceeds during a stall, so the buffer refills.
- PC arithmetic is 32-bit modulo: 32'hFFFF_FFFC+4 = 0.
- `imem_rsp_valid` in REQ or FULL is ignored.

## Timing
- Reset values: state=REQ, pc=`RESET_PC`, `if_valid`=0, `if_pc`=`RESET_PC`, `if_instr`=32'h0000_0013 (NOP), counters=0.
- `imem_req_valid` is 0 while `reset`=1 and 1 in the first cycle after deassertion.
- Latency: a response in cycle N gives `if_valid`=1 in cycle N+1.
- Throughput with 1-cycle memory and `IFU_run`=1 is one instruction per 2 cycles.
- Redirect (any state, priority over everything):
  - `imem_req_valid` is forced 0 that cycle.
  - pc<={`redirect_pc`[31:2],2'b00} and `if_valid`<=0.
  - WAIT without `imem_rsp_valid`: go to DROP.
  - WAIT or DROP with `imem_rsp_valid` in the same cycle: the response is discarded, go to REQ.
  - REQ, FULL: go to REQ.
- Reset mid-operation returns to reset values next edge. Instruction memory shares `reset`, so no stale response follows.
- `if_*` outputs are registered, with no combinational path from inputs.

## Configuration
- `IFU_PERF_EN` defined:
  - `stall_cnt` +1 each cycle with state FULL and `IFU_run`=0.
  - `fetch_cnt` +1 each response loaded into the buffer; discarded responses are not counted.
  - Both counters wrap at 2^32 and clear on reset.
- `IFU_PERF_EN` undefined: both ports are tied to 0 and no counter flops exist. The port list is unchanged.

## Test plan
- Reset release, `RESET_PC`=32'h100, 1-cycle memory returning 0xA0,0xA1,0xA2, `IFU_run`=1 -> addresses 0x100,0x104,0x108. `if_valid` pulses with (0x100,0xA0),(0x104,0xA1),(0x108,0xA2), one per 2 cycles.
- `IFU_run`=0 for 5 cycles while FULL -> `if_*` stable and no request issued. `stall_cnt`=5 with `IFU_PERF_EN`, else 0. Resume -> next address is pc+4.
- Redirect to 0x203 while in WAIT -> DROP. Late response discarded, `if_valid` stays 0. Next request addr 0x200. `fetch_cnt` excludes the dropped word.
- Redirect and `imem_rsp_valid` in the same cycle in WAIT -> response discarded. Request for the redirect PC issued the following cycle.
- `imem_req_ready` held 0 for 3 cycles -> `imem_req_valid`=1 and addr stable until accepted.
- Assert `reset` mid-WAIT -> next cycle state REQ at `RESET_PC`, `if_valid`=0, `if_instr`=0x13.
